shift_pattern_gen: RTL and testbench

SHIFT_PATTERN_GEN -- requirements
Module: shift_pattern_gen

---
 rtl/shift_pattern_pkg.sv | 11 +
 rtl/shift_pattern_if.sv | 28 ++
 rtl/shift_pattern_fb.sv | 25 ++
 rtl/shift_pattern_gen.sv | 72 +++++++
 tb/tb_shift_pattern_gen.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/shift_pattern_pkg.sv
// Shared types for the shift-pattern generator: the 2-bit feedback mode select.
package shift_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_RING    = 2'b00,
        MODE_JOHNSON = 2'b01,
        MODE_FILL    = 2'b10,
        MODE_LFSR    = 2'b11
    } mode_t;

endpackage

// File: rtl/shift_pattern_if.sv
// Control/status bundle of the shift-pattern generator; master drives controls, slave is the generator.
interface shift_pattern_if #(
    parameter int WIDTH = 7,
    parameter int CNT_W = 16
);
    import shift_pattern_pkg::*;

    logic             en;
    mode_t            mode;
    logic             fill_bit;
    logic             load;
    logic [WIDTH-1:0] load_data;
    logic [WIDTH-1:0] q;
    logic             wrap;
    logic [CNT_W-1:0] step_cnt;
    logic [CNT_W-1:0] period;

    modport master (
        output en, mode, fill_bit, load, load_data,
        input  q, wrap, step_cnt, period
    );

    modport slave (
        input  en, mode, fill_bit, load, load_data,
        output q, wrap, step_cnt, period
    );

endinterface

// File: rtl/shift_pattern_fb.sv
// Combinational feedback bit for stage 0 of the shift chain, selected by mode.
module shift_pattern_fb
    import shift_pattern_pkg::*;
#(
    parameter int               WIDTH = 7,
    parameter logic [WIDTH-1:0] TAPS  = '0
) (
    input  logic [WIDTH-1:0] q,
    input  mode_t            mode,
    input  logic             fill_bit,
    output logic             fb
);

    always_comb begin
        fb = q[WIDTH-1];
        case (mode)
            MODE_RING:    fb = q[WIDTH-1];
            MODE_JOHNSON: fb = ~q[WIDTH-1];
            MODE_FILL:    fb = fill_bit;
            // all-zero state would lock an XOR LFSR, so force a 1 in
            MODE_LFSR:    fb = (q == '0) ? 1'b1 : ^(q & TAPS);
        endcase
    end

endmodule

// File: rtl/shift_pattern_gen.sv
// Shift-chain pattern generator: chain, seed register, step counter, period capture and wrap pulse.
module shift_pattern_gen
    import shift_pattern_pkg::*;
#(
    parameter int               WIDTH     = 7,
    parameter logic [WIDTH-1:0] INV_MASK  = '0,
    parameter logic [WIDTH-1:0] TAPS      = '0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    shift_pattern_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] seed_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] period_reg;
    logic             wrap_reg;
    logic             fb;
    logic [WIDTH-1:0] q_next;
    logic [CNT_W-1:0] cnt_next;

    shift_pattern_fb #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_fb (
        .q        (q_reg),
        .mode     (bus.mode),
        .fill_bit (bus.fill_bit),
        .fb       (fb)
    );

    // INV_MASK[0] has no upstream stage, so only bits 1.. participate
    assign q_next   = {q_reg[WIDTH-2:0] ^ INV_MASK[WIDTH-1:1], fb};
    assign cnt_next = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg      <= RESET_VAL;
            seed_reg   <= RESET_VAL;
            cnt_reg    <= '0;
            period_reg <= '0;
            wrap_reg   <= 1'b0;
        end else begin
            wrap_reg <= 1'b0;
            if (bus.load) begin
                q_reg    <= bus.load_data;
                seed_reg <= bus.load_data;
                cnt_reg  <= '0;
            end else if (bus.en) begin
                q_reg <= q_next;
                if (q_next == seed_reg) begin
                    wrap_reg   <= 1'b1;
                    period_reg <= cnt_next;
                    cnt_reg    <= '0;
                end else begin
                    cnt_reg <= cnt_next;
                end
            end
        end
    end

    assign bus.q        = q_reg;
    assign bus.wrap     = wrap_reg;
    assign bus.step_cnt = cnt_reg;
    assign bus.period   = period_reg;

endmodule

// File: tb/tb_shift_pattern_gen.sv
// Table-driven bench for shift_pattern_gen over three parameterisations, with scoreboard queue and reset corner cases.
module tb_shift_pattern_gen;
    import shift_pattern_pkg::*;

    logic clk = 1'b0;
    logic clk_run = 1'b1;
    logic rst_n = 1'b0;

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    // dut 0: WIDTH 7, narrow counter to reach saturation quickly
    shift_pattern_if #(.WIDTH(7), .CNT_W(4))  b0 ();
    // dut 1: WIDTH 4, LFSR taps, non-zero reset value
    shift_pattern_if #(.WIDTH(4), .CNT_W(16)) b1 ();
    // dut 2: WIDTH 7 with stage 4 inverting
    shift_pattern_if #(.WIDTH(7), .CNT_W(16)) b2 ();

    shift_pattern_gen #(.WIDTH(7), .INV_MASK(7'h00), .TAPS(7'h00), .RESET_VAL(7'h00), .CNT_W(4))
        u_dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    shift_pattern_gen #(.WIDTH(4), .INV_MASK(4'h0), .TAPS(4'b1100), .RESET_VAL(4'b1010), .CNT_W(16))
        u_dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    shift_pattern_gen #(.WIDTH(7), .INV_MASK(7'b0010000), .TAPS(7'h00), .RESET_VAL(7'h00), .CNT_W(16))
        u_dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));

    typedef struct {
        int          dut;
        logic        en;
        mode_t       mode;
        logic        fill;
        logic        load;
        logic [7:0]  ld;
        logic [7:0]  exp_q;
        logic        exp_wrap;
        logic [15:0] exp_cnt;
        logic [15:0] exp_per;
    } vec_t;

    typedef struct {
        logic [7:0]  q;
        logic        wrap;
        logic [15:0] cnt;
        logic [15:0] per;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic void add(input int d, input logic en, input mode_t m, input logic f,
                                input logic ld_en, input logic [7:0] ld, input logic [7:0] q,
                                input logic w, input logic [15:0] c, input logic [15:0] p);
        vec_t v;
        v.dut = d; v.en = en; v.mode = m; v.fill = f; v.load = ld_en; v.ld = ld;
        v.exp_q = q; v.exp_wrap = w; v.exp_cnt = c; v.exp_per = p;
        tbl.push_back(v);
    endfunction

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    task automatic idle_all();
        b0.en = 1'b0; b0.load = 1'b0;
        b1.en = 1'b0; b1.load = 1'b0;
        b2.en = 1'b0; b2.load = 1'b0;
    endtask

    task automatic drive(input vec_t v);
        idle_all();
        case (v.dut)
            0: begin
                b0.en = v.en; b0.mode = v.mode; b0.fill_bit = v.fill;
                b0.load = v.load; b0.load_data = v.ld[6:0];
            end
            1: begin
                b1.en = v.en; b1.mode = v.mode; b1.fill_bit = v.fill;
                b1.load = v.load; b1.load_data = v.ld[3:0];
            end
            default: begin
                b2.en = v.en; b2.mode = v.mode; b2.fill_bit = v.fill;
                b2.load = v.load; b2.load_data = v.ld[6:0];
            end
        endcase
    endtask

    task automatic sample(input int d, output logic [7:0] q, output logic w,
                          output logic [15:0] c, output logic [15:0] p);
        case (d)
            0: begin
                q = {1'b0, b0.q}; w = b0.wrap; c = {12'h0, b0.step_cnt}; p = {12'h0, b0.period};
            end
            1: begin
                q = {4'h0, b1.q}; w = b1.wrap; c = b1.step_cnt; p = b1.period;
            end
            default: begin
                q = {1'b0, b2.q}; w = b2.wrap; c = b2.step_cnt; p = b2.period;
            end
        endcase
    endtask

    task automatic check_all(input string tag, input int d, input logic [7:0] q,
                             input logic w, input logic [15:0] c, input logic [15:0] p);
        logic [7:0]  aq;
        logic        aw;
        logic [15:0] ac;
        logic [15:0] ap;
        sample(d, aq, aw, ac, ap);
        check($sformatf("%s.q", tag),        aq, q);
        check($sformatf("%s.wrap", tag),     aw, w);
        check($sformatf("%s.step_cnt", tag), ac, c);
        check($sformatf("%s.period", tag),   ap, p);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  lfsr_seq [15];
        logic [7:0]  aq;
        logic        aw;
        logic [15:0] ac;
        logic [15:0] ap;
        exp_t        e;

        lfsr_seq = '{4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA, 4'h5,
                     4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};

        // dut 0: fill with ones, saturate counter, drain with zeros to wrap
        for (int i = 1; i <= 7; i++)
            add(0, 1, MODE_FILL, 1, 0, 0, 8'((1 << i) - 1), 0, 16'(i), 0);
        for (int i = 8; i <= 20; i++)
            add(0, 1, MODE_FILL, 1, 0, 0, 8'h7F, 0, (i > 15) ? 16'd15 : 16'(i), 0);
        for (int i = 1; i <= 6; i++)
            add(0, 1, MODE_FILL, 0, 0, 0, 8'((8'h7F << i) & 8'h7F), 0, 15, 0);
        add(0, 1, MODE_FILL, 0, 0, 0,     8'h00, 1, 0, 15);
        add(0, 0, MODE_LFSR, 0, 0, 0,     8'h00, 0, 0, 15);
        add(0, 1, MODE_FILL, 1, 1, 8'h55, 8'h55, 0, 0, 15);
        add(0, 1, MODE_FILL, 1, 0, 0,     8'h2B, 0, 1, 15);
        for (int i = 0; i < 5; i++)
            add(0, 0, mode_t'(i[1:0]), i[0], 0, 8'h12, 8'h2B, 0, 1, 15);

        // dut 1: Johnson from 0, ring from 0001, LFSR period, lock-up escape
        add(1, 0, MODE_JOHNSON, 0, 1, 8'h0, 8'h0, 0, 0, 0);
        add(1, 1, MODE_JOHNSON, 0, 0, 0, 8'h1, 0, 1, 0);
        add(1, 1, MODE_JOHNSON, 0, 0, 0, 8'h3, 0, 2, 0);
        add(1, 1, MODE_JOHNSON, 0, 0, 0, 8'h7, 0, 3, 0);
        add(1, 1, MODE_JOHNSON, 0, 0, 0, 8'hF, 0, 4, 0);
        add(1, 1, MODE_JOHNSON, 0, 0, 0, 8'hE, 0, 5, 0);
        add(1, 1, MODE_JOHNSON, 0, 0, 0, 8'hC, 0, 6, 0);
        add(1, 1, MODE_JOHNSON, 0, 0, 0, 8'h8, 0, 7, 0);
        add(1, 1, MODE_JOHNSON, 0, 0, 0, 8'h0, 1, 0, 8);
        add(1, 1, MODE_JOHNSON, 0, 0, 0, 8'h1, 0, 1, 8);
        add(1, 0, MODE_RING,    0, 1, 8'h1, 8'h1, 0, 0, 8);
        add(1, 1, MODE_RING,    0, 0, 0, 8'h2, 0, 1, 8);
        add(1, 1, MODE_RING,    0, 0, 0, 8'h4, 0, 2, 8);
        add(1, 1, MODE_RING,    0, 0, 0, 8'h8, 0, 3, 8);
        add(1, 1, MODE_RING,    0, 0, 0, 8'h1, 1, 0, 4);
        add(1, 0, MODE_LFSR,    0, 1, 8'h1, 8'h1, 0, 0, 4);
        for (int i = 0; i < 15; i++)
            add(1, 1, MODE_LFSR, 0, 0, 0, {4'h0, lfsr_seq[i]}, (i == 14),
                (i == 14) ? 16'd0 : 16'(i + 1), (i == 14) ? 16'd15 : 16'd4);
        add(1, 0, MODE_LFSR, 0, 1, 8'h0, 8'h0, 0, 0, 15);
        add(1, 1, MODE_LFSR, 0, 0, 0,    8'h1, 0, 1, 15);

        // dut 2: Johnson with inverting stage 4
        add(2, 1, MODE_JOHNSON, 0, 0, 0, 8'h11, 0, 1, 0);
        add(2, 1, MODE_JOHNSON, 0, 0, 0, 8'h33, 0, 2, 0);
        add(2, 1, MODE_JOHNSON, 0, 0, 0, 8'h77, 0, 3, 0);
        add(2, 1, MODE_JOHNSON, 0, 0, 0, 8'h7E, 0, 4, 0);

        idle_all();
        b0.mode = MODE_RING; b0.fill_bit = 1'b0; b0.load_data = '0;
        b1.mode = MODE_RING; b1.fill_bit = 1'b0; b1.load_data = '0;
        b2.mode = MODE_RING; b2.fill_bit = 1'b0; b2.load_data = '0;

        #12;
        check_all("rst0", 0, 8'h00, 0, 0, 0);
        check_all("rst1", 1, 8'h0A, 0, 0, 0);
        check_all("rst2", 2, 8'h00, 0, 0, 0);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i]);
            e.q = tbl[i].exp_q; e.wrap = tbl[i].exp_wrap;
            e.cnt = tbl[i].exp_cnt; e.per = tbl[i].exp_per;
            sb.push_back(e);
            @(posedge clk);
            #1;
            sample(tbl[i].dut, aq, aw, ac, ap);
            e = sb.pop_front();
            check($sformatf("v%0d.q", i),        aq, e.q);
            check($sformatf("v%0d.wrap", i),     aw, e.wrap);
            check($sformatf("v%0d.step_cnt", i), ac, e.cnt);
            check($sformatf("v%0d.period", i),   ap, e.per);
            $display("vec %0d dut%0d en=%0b load=%0b mode=%0d -> q=%0h wrap=%0b cnt=%0d per=%0d",
                     i, tbl[i].dut, tbl[i].en, tbl[i].load, tbl[i].mode, aq, aw, ac, ap);
        end
        idle_all();

        // stop the clock low, then reset asynchronously mid-sequence
        @(negedge clk);
        #1;
        clk_run = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check_all("arst0", 0, 8'h00, 0, 0, 0);
        check_all("arst1", 1, 8'h0A, 0, 0, 0);
        check_all("arst2", 2, 8'h00, 0, 0, 0);
        #2;
        rst_n = 1'b1;
        b1.mode = MODE_RING;
        b1.en   = 1'b1;
        #2;
        check_all("post_rst_hold", 1, 8'h0A, 0, 0, 0);
        clk_run = 1'b1;
        @(posedge clk);
        #1;
        check_all("first_step", 1, 8'h05, 0, 1, 0);
        check_all("first_step_idle", 0, 8'h00, 0, 0, 0);
        idle_all();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
